uart_ram_arbiter: RTL and testbench



---
 rtl/uart_ram_arbiter.sv | 148 ++++++++++++++
 tb/tb_uart_ram_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_ram_arbiter.sv
// uart_ram_arbiter: shares one single-port synchronous frame-buffer RAM
// between the display prefetch path (strict priority) and the UART pixel
// writer, whose writes are queued and committed on cycles with no read.
// Build option: define UART_RAM_ARB_WR_FIFO_EN for a 4-entry write FIFO;
// left undefined, a single holding register buffers one write at a time.
module uart_ram_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 24,
  parameter int FB_DEPTH = 65536
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Wr_Valid,
  output logic              Wr_Ready,
  input  logic [ADDR_W-1:0] Wr_Addr,
  input  logic [DATA_W-1:0] Wr_Data,
  input  logic              Data_Req,
  input  logic              VGA_VS,
  output logic [DATA_W-1:0] DATA,
  output logic              Underrun,
  output logic [ADDR_W-1:0] Ram_Addr,
  output logic              Ram_We,
  output logic [DATA_W-1:0] Ram_Wdata,
  input  logic [DATA_W-1:0] Ram_Rdata
);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_DEPTH - 1);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;

  logic              r_vs_d;
  logic              r_flush;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [1:0]        r_occ;
  logic              r_inflight;
  logic              r_head;
  logic [DATA_W-1:0] r_buf [2];

  logic              w_vs_fall;
  logic              w_pop;
  logic [2:0]        w_level;
  logic              w_issue;
  logic              w_wq_ne;
  logic              w_wr_go;
  logic              w_push_wq;
  wr_req_t           w_wq_head;

  // A VS fall seen this cycle flushes the prefetch state at this edge; the
  // following cycle (r_flush) issues no read so refill restarts cleanly.
  assign w_vs_fall = r_vs_d & ~VGA_VS;
  assign w_pop     = Data_Req & (r_occ != 2'd0);
  assign w_level   = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue   = ~r_flush & (w_level < 3'd2);
  assign w_wr_go   = ~w_issue & w_wq_ne;
  assign w_push_wq = Wr_Valid & Wr_Ready;

  assign DATA      = (r_occ != 2'd0) ? r_buf[r_head] : '0;
  assign Underrun  = Data_Req & (r_occ == 2'd0);
  assign Ram_We    = w_wr_go;
  assign Ram_Addr  = w_wr_go ? w_wq_head.addr : r_rd_ptr;
  assign Ram_Wdata = w_wr_go ? w_wq_head.data : '0;

  // Prefetch buffer, read pointer and frame-sync flush.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_vs_d     <= 1'b0;
      r_flush    <= 1'b0;
      r_rd_ptr   <= '0;
      r_occ      <= 2'd0;
      r_inflight <= 1'b0;
      r_head     <= 1'b0;
      r_buf[0]   <= '0;
      r_buf[1]   <= '0;
    end else begin
      r_vs_d  <= VGA_VS;
      r_flush <= w_vs_fall;
      if (w_vs_fall) begin
        // Dropping r_inflight discards the return of any read issued now.
        r_rd_ptr   <= '0;
        r_occ      <= 2'd0;
        r_inflight <= 1'b0;
        r_head     <= 1'b0;
      end else begin
        if (w_issue)
          r_rd_ptr <= (r_rd_ptr == LAST_ADDR) ? '0 : r_rd_ptr + ADDR_W'(1);
        r_inflight <= w_issue;
        // Tail slot is head+occ; level<=2 guarantees no overflow.
        if (r_inflight)
          r_buf[r_head ^ r_occ[0]] <= Ram_Rdata;
        if (w_pop)
          r_head <= ~r_head;
        r_occ <= r_occ + {1'b0, r_inflight} - {1'b0, w_pop};
      end
    end
  end

`ifdef UART_RAM_ARB_WR_FIFO_EN
  wr_req_t    r_wq [4];
  logic [1:0] r_wq_wp;
  logic [1:0] r_wq_rp;
  logic [2:0] r_wq_cnt;

  assign Wr_Ready  = (r_wq_cnt != 3'd4);
  assign w_wq_ne   = (r_wq_cnt != 3'd0);
  assign w_wq_head = r_wq[r_wq_rp];

  // Circular write FIFO: push on handshake, pop when the RAM takes a write.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < 4; i++) r_wq[i] <= '0;
      r_wq_wp  <= 2'd0;
      r_wq_rp  <= 2'd0;
      r_wq_cnt <= 3'd0;
    end else begin
      if (w_push_wq) begin
        r_wq[r_wq_wp] <= '{addr: Wr_Addr, data: Wr_Data};
        r_wq_wp       <= r_wq_wp + 2'd1;
      end
      if (w_wr_go)
        r_wq_rp <= r_wq_rp + 2'd1;
      r_wq_cnt <= r_wq_cnt + {2'b00, w_push_wq} - {2'b00, w_wr_go};
    end
  end
`else
  logic    r_hv;
  wr_req_t r_hold;

  assign Wr_Ready  = ~r_hv;
  assign w_wq_ne   = r_hv;
  assign w_wq_head = r_hold;

  // Single holding register: full from acceptance until committed.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_hv   <= 1'b0;
      r_hold <= '0;
    end else if (w_push_wq) begin
      r_hv   <= 1'b1;
      r_hold <= '{addr: Wr_Addr, data: Wr_Data};
    end else if (w_wr_go) begin
      r_hv   <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_uart_ram_arbiter.sv
// Directed bench for uart_ram_arbiter: reset/refill, active line with
// queued writes, blanking drain, rd_ptr wrap (second small instance),
// VS flush, underrun and reset mid-operation.
`timescale 1ns/1ps
module tb_uart_ram_arbiter;
  localparam int AW = 16;
  localparam int DW = 24;
`ifdef UART_RAM_ARB_WR_FIFO_EN
  localparam int QD    = 4;
  localparam int CSTEP = 1;
`else
  localparam int QD    = 1;
  localparam int CSTEP = 2;
`endif

  logic          Clk = 1'b0;
  logic          Reset_n = 1'b0;
  logic          Wr_Valid = 1'b0;
  logic          Wr_Ready;
  logic [AW-1:0] Wr_Addr = '0;
  logic [DW-1:0] Wr_Data = '0;
  logic          Data_Req = 1'b0;
  logic          VGA_VS = 1'b1;
  logic [DW-1:0] DATA;
  logic          Underrun;
  logic [AW-1:0] Ram_Addr;
  logic          Ram_We;
  logic [DW-1:0] Ram_Wdata;
  logic [DW-1:0] Ram_Rdata;

  logic          Data_Req2 = 1'b0;
  logic          Wr_Ready2;
  logic [DW-1:0] DATA2;
  logic          Underrun2;
  logic [AW-1:0] Ram_Addr2;
  logic          Ram_We2;
  logic [DW-1:0] Ram_Wdata2;
  logic [DW-1:0] Ram_Rdata2;

  int checks = 0;
  int errors = 0;

  // RAM model: unwritten locations read back as their own address.
  logic [DW-1:0] mem [65536];
  bit            mv  [65536];

  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    if (Ram_We) begin
      mem[Ram_Addr] <= Ram_Wdata;
      mv[Ram_Addr]  <= 1'b1;
    end
    Ram_Rdata  <= mv[Ram_Addr] ? mem[Ram_Addr] : DW'(Ram_Addr);
    Ram_Rdata2 <= DW'(Ram_Addr2);
  end

  uart_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FB_DEPTH(65536)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Wr_Valid(Wr_Valid), .Wr_Ready(Wr_Ready),
    .Wr_Addr(Wr_Addr), .Wr_Data(Wr_Data), .Data_Req(Data_Req), .VGA_VS(VGA_VS),
    .DATA(DATA), .Underrun(Underrun), .Ram_Addr(Ram_Addr), .Ram_We(Ram_We),
    .Ram_Wdata(Ram_Wdata), .Ram_Rdata(Ram_Rdata));

  uart_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FB_DEPTH(16)) dut16 (
    .Clk(Clk), .Reset_n(Reset_n), .Wr_Valid(1'b0), .Wr_Ready(Wr_Ready2),
    .Wr_Addr('0), .Wr_Data('0), .Data_Req(Data_Req2), .VGA_VS(1'b1),
    .DATA(DATA2), .Underrun(Underrun2), .Ram_Addr(Ram_Addr2), .Ram_We(Ram_We2),
    .Ram_Wdata(Ram_Wdata2), .Ram_Rdata(Ram_Rdata2));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Hold a write until accepted (bounded), then release Wr_Valid.
  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n = 0;
    Wr_Valid = 1'b1; Wr_Addr = a; Wr_Data = d;
    #1;
    while (!Wr_Ready && n < 20) begin
      @(posedge Clk);
      #2;
      n++;
    end
    check("wr_accept", 32'(Wr_Ready), 32'd1);
    tick();
    Wr_Valid = 1'b0;
  endtask

  initial begin
    int  wk;
    int  nc;
    bit  hs;

    // Reset state
    tick(); tick();
    #1;
    check("rst_data", 32'(DATA), 32'd0);
    check("rst_underrun", 32'(Underrun), 32'd0);
    check("rst_we", 32'(Ram_We), 32'd0);
    check("rst_addr", 32'(Ram_Addr), 32'd0);
    check("rst_wdata", 32'(Ram_Wdata), 32'd0);
    check("rst_wr_ready", 32'(Wr_Ready), 32'd1);
    check("rst_wr_ready16", 32'(Wr_Ready2), 32'd1);
    check("rst_wdata16", 32'(Ram_Wdata2), 32'd0);

    // Refill: addr 0, addr 1, then idle at rd_ptr=2
    Reset_n = 1'b1;
    #1;
    check("refill_addr0", 32'(Ram_Addr), 32'd0);
    check("refill_data_empty", 32'(DATA), 32'd0);
    tick(); #1;
    check("refill_addr1", 32'(Ram_Addr), 32'd1);
    tick(); #1;
    check("refill_idle_addr", 32'(Ram_Addr), 32'd2);
    check("refill_idle_we", 32'(Ram_We), 32'd0);
    tick(); #1;
    check("refill_hold_addr", 32'(Ram_Addr), 32'd2);
    check("refill_head", 32'(DATA), 32'd0);
    tick();

    // Wrap on the FB_DEPTH=16 instance: 0..15 then 0..3
    for (int k = 0; k < 20; k++) begin
      Data_Req2 = 1'b1;
      #1;
      check("wrap_data", 32'(DATA2), 32'(k % 16));
      check("wrap_underrun", 32'(Underrun2), 32'd0);
      check("wrap_we", 32'(Ram_We2), 32'd0);
      tick();
    end
    Data_Req2 = 1'b0;

    // Active line of 800 pixels; 4 writes offered from pixel 100
    wk = 0;
    for (int c = 0; c < 800; c++) begin
      Data_Req = 1'b1;
      Wr_Valid = (c >= 100 && wk < 4);
      Wr_Addr  = AW'(16 + wk);
      Wr_Data  = DW'(32'hA5A5A0 + wk);
      #1;
      check("active_data", 32'(DATA), 32'(c));
      check("active_underrun", 32'(Underrun), 32'd0);
      check("active_we", 32'(Ram_We), 32'd0);
      if (c == 110) begin
        check("wr_ready_low", 32'(Wr_Ready), 32'd0);
        check("wr_accepted", 32'(wk), 32'(QD));
      end
      hs = Wr_Valid && Wr_Ready;
      tick();
      if (hs) wk++;
    end

    // Blanking: queued writes drain
    Data_Req = 1'b0;
    nc = 0;
    for (int c = 0; c < 12; c++) begin
      Wr_Valid = (wk < 4);
      Wr_Addr  = AW'(16 + wk);
      Wr_Data  = DW'(32'hA5A5A0 + wk);
      #1;
      if (Ram_We) begin
        check("commit_addr", 32'(Ram_Addr), 32'(16 + nc));
        check("commit_data", 32'(Ram_Wdata), 32'hA5A5A0 + 32'(nc));
        check("commit_cycle", 32'(c), 32'(nc * CSTEP));
        nc++;
      end
      hs = Wr_Valid && Wr_Ready;
      tick();
      if (hs) wk++;
    end
    Wr_Valid = 1'b0;
    check("commit_count", 32'(nc), 32'd4);
    for (int j = 0; j < 4; j++)
      check("commit_mem", 32'(mem[AW'(16 + j)]), 32'hA5A5A0 + 32'(j));

    // Keep popping until rd_ptr lands on 0x1234
    for (int p = 800; p <= 32'h1231; p++) begin
      Data_Req = 1'b1;
      #1;
      check("line2_data", 32'(DATA), 32'(p));
      tick();
    end
    Data_Req = 1'b0;

    // Give mem[0], mem[1] distinct values for the flush tests
    do_write(16'h0000, 24'hABCDEF);
    do_write(16'h0001, 24'h123456);
    tick(); tick(); tick(); tick();
    check("mem0_written", 32'(mem[0]), 32'hABCDEF);
    check("mem1_written", 32'(mem[1]), 32'h123456);
    #1;
    check("rd_ptr_pre_vs", 32'(Ram_Addr), 32'h1234);
    tick();

    // VS flush: one-cycle gap, then reads restart at 0
    VGA_VS = 1'b0;
    #1;
    check("vs_detect_addr", 32'(Ram_Addr), 32'h1234);
    tick(); #1;
    check("flush_data", 32'(DATA), 32'd0);
    check("flush_addr", 32'(Ram_Addr), 32'd0);
    tick(); #1;
    check("flush_issue0", 32'(Ram_Addr), 32'd0);
    tick(); #1;
    check("flush_issue1", 32'(Ram_Addr), 32'd1);
    tick(); #1;
    check("flush_first", 32'(DATA), 32'hABCDEF);
    check("flush_idle", 32'(Ram_Addr), 32'd2);
    tick();

    // Second flush, Data_Req pulsed one cycle after it
    VGA_VS = 1'b1;
    tick(); tick();
    VGA_VS = 1'b0;
    tick(); #1;
    check("uf_flush_under", 32'(Underrun), 32'd0);
    check("uf_flush_data", 32'(DATA), 32'd0);
    tick();
    Data_Req = 1'b1;
    #1;
    check("uf_underrun", 32'(Underrun), 32'd1);
    check("uf_data", 32'(DATA), 32'd0);
    tick();
    Data_Req = 1'b0;
    #1;
    check("uf_after", 32'(Underrun), 32'd0);
    tick();
    Data_Req = 1'b1;
    #1;
    check("uf_pix0", 32'(DATA), 32'hABCDEF);
    check("uf_pix0_under", 32'(Underrun), 32'd0);
    tick(); #1;
    check("uf_pix1", 32'(DATA), 32'h123456);
    check("uf_pix1_under", 32'(Underrun), 32'd0);
    tick();

    // Reset mid-operation: a queued write is lost, refill from 0
    Wr_Valid = 1'b1; Wr_Addr = 16'h0020; Wr_Data = 24'h777777;
    #1;
    check("mid_wr_ready", 32'(Wr_Ready), 32'd1);
    tick();
    Wr_Valid = 1'b0;
    Data_Req = 1'b0;
    Reset_n  = 1'b0;
    #1;
    check("mid_rst_ready", 32'(Wr_Ready), 32'd1);
    check("mid_rst_we", 32'(Ram_We), 32'd0);
    check("mid_rst_data", 32'(DATA), 32'd0);
    check("mid_rst_addr", 32'(Ram_Addr), 32'd0);
    tick();
    Reset_n = 1'b1;
    #1;
    check("mid_refill0", 32'(Ram_Addr), 32'd0);
    check("mid_refill_we", 32'(Ram_We), 32'd0);
    tick(); tick(); #1;
    check("mid_refill_head", 32'(DATA), 32'hABCDEF);
    tick(); tick(); tick();
    check("mid_write_lost", 32'(mv[16'h0020]), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
